mem_arbiter: RTL

- Shares a single unified memory bus between the pipelined core's instruction fetch port (pcF/instrF) and its data port (memreadM/memwriteM/aluoutM/writedataM/mem_sizeM/readdataM).
- The bus has a variable-latency req/ack handshake.
- Sequences one transaction at a time and returns per-port ready pulses.
- Raises a stall to the core while any request is outstanding.
- Data-over-fetch priority, with a starvation guard for fetch.

---
 rtl/mem_arbiter.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Purpose : shares one req/ack memory bus between the core's fetch port and data port.
// Latency : request sampled at edge k drives mem_req after k; ack at edge m pulses ready during m..m+1.
// Backpressure: one bus transaction at a time, data wins over fetch unless fetch has starved; stall covers waits.
//
// Ports:
//   clk, reset                      - rising-edge clock, asynchronous active-low reset
//   if_req/if_addr/if_rdata/if_ready - instruction fetch port (request held until if_ready)
//   d_req/d_we/d_size/d_addr/d_wdata/d_rdata/d_ready - data port (request held until d_ready)
//   mem_req/mem_we/mem_size/mem_addr/mem_wdata/mem_rdata/mem_ack - unified memory bus
//   stall                           - core stall while any port request is outstanding
//   bus_err                         - sticky bus timeout flag
//
// Build option: define ARB_TIMEOUT_EN to abort transactions that see no mem_ack for
// TIMEOUT_CYCLES cycles; otherwise the arbiter waits indefinitely and bus_err is tied low.

module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,

    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,

    output logic        stall,
    output logic        bus_err
);

    // Parameter sanity: fetch must eventually be forced past data.
    if (STARVE_LIMIT < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_arbiter: STARVE_LIMIT and TIMEOUT_CYCLES must both be at least 1");
    end

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t        state_q,     state_d;
    logic [SW-1:0] starve_q,    starve_d;
    logic          mem_req_q,   mem_req_d;
    logic          mem_we_q,    mem_we_d;
    logic [1:0]    mem_size_q,  mem_size_d;
    logic [31:0]   mem_addr_q,  mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   if_rdata_q,  if_rdata_d;
    logic [31:0]   d_rdata_q,   d_rdata_d;
    logic          if_ready_q,  if_ready_d;
    logic          d_ready_q,   d_ready_d;

    // Transaction finish (ack or abort) and the word returned to the port.
    logic          done;
    logic [31:0]   done_rdata;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          bus_err_q, bus_err_d;
`endif

    // Fetch has watched STARVE_LIMIT data completions go by: it wins the next grant.
    logic fetch_forced;
    assign fetch_forced = if_req && (starve_q == SW'(STARVE_LIMIT));

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_size_d  = mem_size_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        done        = 1'b0;
        done_rdata  = mem_rdata;
`ifdef ARB_TIMEOUT_EN
        tmo_d       = tmo_q;
        bus_err_d   = bus_err_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (!if_req) begin
                    starve_d = '0;
                end
                if (d_req && !fetch_forced) begin
                    state_d     = DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_size_d  = d_size;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
`ifdef ARB_TIMEOUT_EN
                    tmo_d       = '0;
`endif
                end else if (if_req) begin
                    // Instruction fetches are always full-word reads.
                    state_d     = FETCH;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_size_d  = 2'b10;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = 32'h0;
                    starve_d    = '0;
`ifdef ARB_TIMEOUT_EN
                    tmo_d       = '0;
`endif
                end
            end

            FETCH, DATA: begin
                if (mem_ack) begin
                    done = 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                // The counter holds the number of ack-less edges already seen, so
                // the abort fires on the TIMEOUT_CYCLES-th one.
                else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    done       = 1'b1;
                    done_rdata = 32'hDEAD_BEEF;
                    bus_err_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
                if (done) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    if (state_q == FETCH) begin
                        if_rdata_d = done_rdata;
                        if_ready_d = 1'b1;
                    end else begin
                        d_rdata_d = done_rdata;
                        d_ready_d = 1'b1;
                        if (if_req && (starve_q != SW'(STARVE_LIMIT))) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_size_q  <= 2'b00;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= 32'h0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_size_q  <= mem_size_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            bus_err_q <= bus_err_d;
        end
    end
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_size  = mem_size_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;

    // A request is "waiting" until the cycle its ready pulse shows up.
    assign stall = (if_req & ~if_ready_q) | (d_req & ~d_ready_q);

endmodule
